// File: rtl/bank_act_ctrl.sv
// Per-bank activate controller: open-row table, PRE/ACT/CAS sequencing
// with tRCD/tRP/tRRD/tFAW/tRTP/tWR spacing and open/closed page policy.
`timescale 1ns/1ps
module bank_act_ctrl #(
    parameter int NUM_BANKS   = 16,
    parameter int RA_WIDTH    = 15,
    parameter int tRCD        = 11,
    parameter int tRP         = 11,
    parameter int tRRD        = 4,
    parameter int tFAW        = 16,
    parameter int tRTP        = 6,
    parameter int tWR         = 12,
    parameter int PAGE_POLICY = 0
) (
    input  logic                         clock_t,
    input  logic                         reset_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [$clog2(NUM_BANKS)-1:0] req_bank,
    input  logic [RA_WIDTH-1:0]          req_row,
    input  logic [7:0]                   wr_delay,
    input  logic                         last_cas_write,
    input  logic                         cas_idle,
    output logic                         act_rdy,
    output logic [$clog2(NUM_BANKS)-1:0] act_bank,
    output logic [RA_WIDTH-1:0]          act_row,
    output logic                         pre_rdy,
    output logic [$clog2(NUM_BANKS)-1:0] pre_bank,
    output logic                         cas_rdy,
    output logic [$clog2(NUM_BANKS)-1:0] cas_bank,
    output logic                         cas_ap,
    output logic                         act_idle
);

    localparam int BW = $clog2(NUM_BANKS);
    localparam int CW = 16;
    localparam logic [CW-1:0] TRCD_M1 = CW'(tRCD > 1 ? tRCD - 1 : 0);
    localparam logic [CW-1:0] TRP_M1  = CW'(tRP > 1 ? tRP - 1 : 0);
    localparam logic [CW-1:0] FAW_M1  = CW'(tFAW > 1 ? tFAW - 1 : 0);
    localparam logic [CW-1:0] TRRD_C  = CW'(tRRD);
    localparam logic [9:0]    TWR_C   = 10'(tWR);
    localparam logic [9:0]    TRTP_C  = 10'(tRTP);
    localparam logic          CLOSED  = (PAGE_POLICY != 0);

    typedef enum logic [3:0] {
        IDLE, CHECK, PRE_WAIT_DATA, PRE_WAIT, PRE_CMD,
        TRP, ACT_WAIT, TRCD, CAS
    } state_e;

    state_e                state_q, state_d;
    logic [BW-1:0]         bank_q, bank_d;
    logic [RA_WIDTH-1:0]   row_q, row_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         rrd_q, rrd_d;
    logic [CW-1:0]         faw_q [4];
    logic [CW-1:0]         faw_d [4];
    logic [NUM_BANKS-1:0]  vld_q, vld_d;
    logic [RA_WIDTH-1:0]   tab_q [NUM_BANKS];
    logic [RA_WIDTH-1:0]   tab_d [NUM_BANKS];

    logic [9:0] n_val;
    logic       hit, rrd_ok, faw_ok, act_ok, cnt_last;
    logic [1:0] faw_sel;

    assign n_val    = last_cas_write ? 10'(wr_delay) + TWR_C + 10'd4 : TRTP_C;
    assign hit      = vld_q[bank_q] && (tab_q[bank_q] == row_q);
    assign rrd_ok   = rrd_q >= TRRD_C;
    assign act_ok   = rrd_ok && faw_ok;
    assign cnt_last = cnt_q <= CW'(1);

    // A zero slot means that ACT has left the four-activate window.
    always_comb begin
        faw_ok  = 1'b0;
        faw_sel = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (faw_q[k] == '0) begin
                faw_ok  = 1'b1;
                faw_sel = 2'(k);
            end
        end
    end

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (req_valid) state_d = CHECK;
            CHECK: begin
                if (hit)                 state_d = IDLE;
                else if (!vld_q[bank_q]) state_d = ACT_WAIT;
                else                     state_d = PRE_WAIT_DATA;
            end
            PRE_WAIT_DATA: begin
                if (cas_idle) state_d = (n_val == '0) ? PRE_CMD : PRE_WAIT;
            end
            PRE_WAIT: if (cnt_last) state_d = PRE_CMD;
            PRE_CMD:  state_d = (TRP_M1 == '0) ? ACT_WAIT : TRP;
            TRP:      if (cnt_last) state_d = ACT_WAIT;
            ACT_WAIT: begin
                if (act_ok) state_d = (TRCD_M1 == '0) ? CAS : TRCD;
            end
            TRCD:     if (cnt_last) state_d = CAS;
            CAS:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        act_idle  = 1'b0;
        act_rdy   = 1'b0;
        act_bank  = '0;
        act_row   = '0;
        pre_rdy   = 1'b0;
        pre_bank  = '0;
        cas_rdy   = 1'b0;
        cas_bank  = '0;
        cas_ap    = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                act_idle  = 1'b1;
            end
            CHECK: begin
                if (hit) begin
                    cas_rdy  = 1'b1;
                    cas_bank = bank_q;
                    cas_ap   = CLOSED;
                end
            end
            PRE_CMD: begin
                pre_rdy  = 1'b1;
                pre_bank = bank_q;
            end
            ACT_WAIT: begin
                if (act_ok) begin
                    act_rdy  = 1'b1;
                    act_bank = bank_q;
                    act_row  = row_q;
                end
            end
            CAS: begin
                cas_rdy  = 1'b1;
                cas_bank = bank_q;
                cas_ap   = CLOSED;
            end
            default: ;
        endcase
    end

    always_comb begin
        bank_d = bank_q;
        row_d  = row_q;
        cnt_d  = cnt_q;
        rrd_d  = rrd_q;
        faw_d  = faw_q;
        vld_d  = vld_q;
        tab_d  = tab_q;
        if (req_ready && req_valid) begin
            bank_d = req_bank;
            row_d  = req_row;
        end
        if (state_q == PRE_WAIT_DATA) cnt_d = CW'(n_val);
        else if (state_q inside {PRE_WAIT, TRP, TRCD}) cnt_d = cnt_q - CW'(1);
        if (pre_rdy) cnt_d = TRP_M1;
        if (act_rdy) cnt_d = TRCD_M1;
        if (act_rdy)     rrd_d = CW'(1);
        else if (!rrd_ok) rrd_d = rrd_q + CW'(1);
        for (int k = 0; k < 4; k++) begin
            if (faw_q[k] != '0) faw_d[k] = faw_q[k] - CW'(1);
        end
        if (act_rdy) faw_d[faw_sel] = FAW_M1;
        if (act_rdy) begin
            vld_d[bank_q] = 1'b1;
            tab_d[bank_q] = row_q;
        end
        if (pre_rdy || (cas_rdy && CLOSED)) vld_d[bank_q] = 1'b0;
    end

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            bank_q <= '0;
            row_q  <= '0;
            cnt_q  <= '0;
            rrd_q  <= TRRD_C;
            vld_q  <= '0;
            for (int k = 0; k < 4; k++) faw_q[k] <= '0;
            for (int b = 0; b < NUM_BANKS; b++) tab_q[b] <= '0;
        end else begin
            bank_q <= bank_d;
            row_q  <= row_d;
            cnt_q  <= cnt_d;
            rrd_q  <= rrd_d;
            vld_q  <= vld_d;
            faw_q  <= faw_d;
            tab_q  <= tab_d;
        end
    end

endmodule
